bank_switch_scheduler: RTL and testbench

- Top-level sequencer for the ifmap and weight double buffers.
- Tracks when each input controller has filled its write bank and when the compute array has finished its read bank.
- Issues the common bank-switch handshake (ready_to_switch, start_new_write_bank) and a compute_start pulse per tile, until config_num_tiles tiles have been computed.
- Sits between the two input controllers and the compute-side FSM.

---
 rtl/bank_switch_scheduler.sv | 115 +++++++++++
 tb/tb_bank_switch_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_switch_scheduler.sv
// Sequences the ifmap/weight double-buffer bank switches and per-tile compute
// launches until the configured tile count has been computed.
module bank_switch_scheduler #(
  parameter int TILE_CNT_WIDTH  = 16,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       config_done,
  input  logic [TILE_CNT_WIDTH-1:0]  config_num_tiles,
  input  logic                       ifmap_bank_ready,
  input  logic                       weight_bank_ready,
  input  logic                       compute_done,
  output logic                       ready_to_switch,
  output logic                       start_new_write_bank,
  output logic                       compute_start,
  output logic [TILE_CNT_WIDTH-1:0]  tile_count,
  output logic                       busy,
  output logic                       all_done,
  output logic                       protocol_err,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SWITCH, S_LAUNCH, S_RUN, S_DONE
  } state_t;

  state_t                      state_q;
  logic [TILE_CNT_WIDTH-1:0]   n_q;
  logic [TILE_CNT_WIDTH-1:0]   tile_q;
  logic [STALL_CNT_WIDTH-1:0]  stall_q;
  logic                        err_q;
  logic                        arm_i_q;
  logic                        arm_w_q;
  logic                        done_seen_q;
  logic                        last_tile;
  logic                        writes_ok;

  assign last_tile = (tile_q == n_q);
  // A ready flag only counts once it has been seen low since the last switch.
  assign writes_ok = last_tile ||
                     (arm_i_q && ifmap_bank_ready && arm_w_q && weight_bank_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      tile_q      <= '0;
      stall_q     <= '0;
      err_q       <= 1'b0;
      arm_i_q     <= 1'b0;
      arm_w_q     <= 1'b0;
      done_seen_q <= 1'b0;
    end else begin
      if (compute_done) begin
        unique case (state_q)
          S_IDLE, S_FILL, S_SWITCH, S_LAUNCH: err_q <= 1'b1;
          S_RUN:   if (done_seen_q) err_q <= 1'b1;
          default: ;
        endcase
      end

      unique case (state_q)
        S_IDLE: begin
          if (config_done) begin
            n_q     <= config_num_tiles;
            tile_q  <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
            state_q <= (config_num_tiles == '0) ? S_DONE : S_FILL;
          end
        end
        S_FILL: begin
          if (ifmap_bank_ready && weight_bank_ready) state_q <= S_SWITCH;
        end
        S_SWITCH: begin
          tile_q      <= tile_q + TILE_CNT_WIDTH'(1);
          arm_i_q     <= 1'b0;
          arm_w_q     <= 1'b0;
          done_seen_q <= 1'b0;
          state_q     <= S_LAUNCH;
        end
        S_LAUNCH: begin
          if (!ifmap_bank_ready)  arm_i_q <= 1'b1;
          if (!weight_bank_ready) arm_w_q <= 1'b1;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (!ifmap_bank_ready)  arm_i_q <= 1'b1;
          if (!weight_bank_ready) arm_w_q <= 1'b1;
          if (compute_done)       done_seen_q <= 1'b1;
          if (done_seen_q && writes_ok) begin
            state_q <= last_tile ? S_DONE : S_SWITCH;
          end else if (done_seen_q && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_CNT_WIDTH'(1);
          end
        end
        S_DONE: begin
          if (!config_done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_to_switch      = (state_q == S_SWITCH);
  assign compute_start        = (state_q == S_LAUNCH);
  assign start_new_write_bank = (state_q == S_LAUNCH) && (tile_q < n_q);
  assign busy                 = (state_q != S_IDLE) && (state_q != S_DONE);
  assign all_done             = (state_q == S_DONE);
  assign tile_count           = tile_q;
  assign stall_count          = stall_q;
  assign protocol_err         = err_q;

endmodule

// File: tb/tb_bank_switch_scheduler.sv
// Scoreboard bench: pulse events expected by the stimulus are queued with their
// cycle number and popped by a negedge monitor whenever the DUT pulses.
module tb_bank_switch_scheduler;

  localparam logic [3:0] EV_RTS     = 4'b1000;
  localparam logic [3:0] EV_SNWB_CS = 4'b0110;
  localparam logic [3:0] EV_CS      = 4'b0010;
  localparam logic [3:0] EV_DONE    = 4'b0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        config_done;
  logic [15:0] config_num_tiles;
  logic        ifmap_bank_ready;
  logic        weight_bank_ready;
  logic        compute_done;
  logic        ready_to_switch;
  logic        start_new_write_bank;
  logic        compute_start;
  logic [15:0] tile_count;
  logic        busy;
  logic        all_done;
  logic        protocol_err;
  logic [15:0] stall_count;

  bank_switch_scheduler #(.TILE_CNT_WIDTH(16), .STALL_CNT_WIDTH(16)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .config_done          (config_done),
    .config_num_tiles     (config_num_tiles),
    .ifmap_bank_ready     (ifmap_bank_ready),
    .weight_bank_ready    (weight_bank_ready),
    .compute_done         (compute_done),
    .ready_to_switch      (ready_to_switch),
    .start_new_write_bank (start_new_write_bank),
    .compute_start        (compute_start),
    .tile_count           (tile_count),
    .busy                 (busy),
    .all_done             (all_done),
    .protocol_err         (protocol_err),
    .stall_count          (stall_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  ev;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic expect_ev(input int unsigned c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.ev  = v;
    expq.push_back(e);
  endtask

  // Monitor: any pulse (or all_done rising) must match the head of the queue.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    logic [3:0] ev;
    exp_t       e;
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      ev = {ready_to_switch, start_new_write_bank, compute_start, all_done & ~prev_done};
      prev_done = all_done;
      if (ev != 4'b0000) begin
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse at cycle %0d: got %b, expected none", cyc, ev);
        end else begin
          e = expq.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_kind", {28'd0, ev}, {28'd0, e.ev});
        end
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto(input int unsigned k);
    while (cyc < k) step(1);
  endtask

  task automatic set_ready(input logic v);
    ifmap_bank_ready  = v;
    weight_bank_ready = v;
  endtask

  task automatic pulse_cd();
    compute_done = 1'b1;
    step(1);
    compute_done = 1'b0;
  endtask

  // Starts a run and fills both banks; returns the first LAUNCH cycle.
  task automatic start_run(input int unsigned n, input bit drop, output int unsigned launch);
    int unsigned s;
    s = cyc;
    config_num_tiles = n[15:0];
    config_done = 1'b1;
    goto(s + 2);
    set_ready(1'b1);
    expect_ev(s + 3, EV_RTS);
    expect_ev(s + 4, (n > 1) ? EV_SNWB_CS : EV_CS);
    goto(s + 3);
    if (drop) set_ready(1'b0);
    launch = s + 4;
  endtask

  task automatic finish_run(input string tag, input int unsigned tiles,
                            input int unsigned stalls, input logic err);
    check({tag, "_all_done"}, {31'd0, all_done}, 32'd1);
    check({tag, "_tile_count"}, {16'd0, tile_count}, tiles);
    check({tag, "_stall_count"}, {16'd0, stall_count}, stalls);
    check({tag, "_protocol_err"}, {31'd0, protocol_err}, {31'd0, err});
    config_done = 1'b0;
    step(2);
    check({tag, "_back_idle"}, {30'd0, busy, all_done}, 32'd0);
    check({tag, "_tile_hold"}, {16'd0, tile_count}, tiles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned L;
    int unsigned s;
    rst = 1'b1;
    config_done = 1'b0;
    config_num_tiles = '0;
    set_ready(1'b0);
    compute_done = 1'b0;
    step(3);
    check("reset_outputs",
          {ready_to_switch, start_new_write_bank, compute_start, busy, all_done, protocol_err},
          32'd0);
    check("reset_tile_count", {16'd0, tile_count}, 32'd0);
    check("reset_stall_count", {16'd0, stall_count}, 32'd0);
    rst = 1'b0;
    step(2);

    // N=1: single tile, write side never restarted.
    start_run(1, 1'b1, L);
    goto(L + 6);
    expect_ev(L + 8, EV_DONE);
    pulse_cd();
    goto(L + 9);
    finish_run("n1", 1, 0, 1'b0);

    // N=3: writes finish early, compute is the bottleneck.
    start_run(3, 1'b1, L);
    for (int t = 1; t <= 3; t++) begin
      if (t < 3) begin
        goto(L + 10);
        set_ready(1'b1);
      end
      goto(L + 30);
      if (t < 3) begin
        expect_ev(L + 32, EV_RTS);
        expect_ev(L + 33, (t + 1 < 3) ? EV_SNWB_CS : EV_CS);
      end else begin
        expect_ev(L + 32, EV_DONE);
      end
      pulse_cd();
      if (t < 3) begin
        goto(L + 32);
        set_ready(1'b0);
        L = L + 33;
      end
    end
    goto(L + 33);
    finish_run("n3", 3, 0, 1'b0);

    // N=2: weight bank late; also a second compute_done while waiting.
    start_run(2, 1'b1, L);
    goto(L + 10);
    ifmap_bank_ready = 1'b1;
    goto(L + 15);
    expect_ev(L + 22, EV_RTS);
    expect_ev(L + 23, EV_CS);
    pulse_cd();
    goto(L + 18);
    pulse_cd();
    check("double_done_err", {31'd0, protocol_err}, 32'd1);
    goto(L + 21);
    weight_bank_ready = 1'b1;
    goto(L + 22);
    set_ready(1'b0);
    L = L + 23;
    goto(L + 5);
    expect_ev(L + 7, EV_DONE);
    pulse_cd();
    goto(L + 8);
    finish_run("slow_w", 2, 5, 1'b1);

    // Stale flags: readies stay high past SWITCH, must drop and rise again.
    start_run(2, 1'b0, L);
    check("err_cleared_on_start", {31'd0, protocol_err}, 32'd0);
    goto(L + 2);
    pulse_cd();
    set_ready(1'b0);
    goto(L + 7);
    expect_ev(L + 8, EV_RTS);
    expect_ev(L + 9, EV_CS);
    set_ready(1'b1);
    goto(L + 8);
    set_ready(1'b0);
    L = L + 9;
    goto(L + 5);
    expect_ev(L + 7, EV_DONE);
    pulse_cd();
    goto(L + 8);
    finish_run("stale", 2, 4, 1'b0);

    // N=0: straight to DONE.
    s = cyc;
    config_num_tiles = 16'd0;
    config_done = 1'b1;
    expect_ev(s + 1, EV_DONE);
    goto(s + 2);
    finish_run("n0", 0, 0, 1'b0);

    // compute_done during FILL flags an error but leaves the run intact.
    s = cyc;
    config_num_tiles = 16'd1;
    config_done = 1'b1;
    goto(s + 2);
    pulse_cd();
    check("fill_done_err", {31'd0, protocol_err}, 32'd1);
    check("fill_still_busy", {31'd0, busy}, 32'd1);
    goto(s + 4);
    set_ready(1'b1);
    expect_ev(s + 5, EV_RTS);
    expect_ev(s + 6, EV_CS);
    goto(s + 5);
    set_ready(1'b0);
    goto(s + 10);
    expect_ev(s + 12, EV_DONE);
    pulse_cd();
    goto(s + 13);
    finish_run("fill_err", 1, 0, 1'b1);

    // Asynchronous reset in the middle of tile 2 of a 3-tile run.
    start_run(3, 1'b1, L);
    check("err_cleared_again", {31'd0, protocol_err}, 32'd0);
    goto(L + 10);
    set_ready(1'b1);
    goto(L + 20);
    expect_ev(L + 22, EV_RTS);
    expect_ev(L + 23, EV_SNWB_CS);
    pulse_cd();
    goto(L + 22);
    set_ready(1'b0);
    L = L + 23;
    goto(L + 5);
    check("pre_reset_tile_count", {16'd0, tile_count}, 32'd2);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_flags",
          {ready_to_switch, start_new_write_bank, compute_start, busy, all_done, protocol_err},
          32'd0);
    check("async_reset_tile_count", {16'd0, tile_count}, 32'd0);
    check("async_reset_stall_count", {16'd0, stall_count}, 32'd0);
    config_done = 1'b0;
    step(2);
    rst = 1'b0;
    step(2);

    // Fresh N=2 run after reset.
    start_run(2, 1'b1, L);
    goto(L + 10);
    set_ready(1'b1);
    goto(L + 20);
    expect_ev(L + 22, EV_RTS);
    expect_ev(L + 23, EV_CS);
    pulse_cd();
    goto(L + 22);
    set_ready(1'b0);
    L = L + 23;
    goto(L + 5);
    expect_ev(L + 7, EV_DONE);
    pulse_cd();
    goto(L + 8);
    finish_run("post_reset", 2, 0, 1'b0);

    step(3);
    check("scoreboard_drained", expq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
